// File: rtl/redmule_pkg.sv
// Shared types and width helpers for the RedMulE MX stream router.
package redmule_pkg;

    typedef enum logic [1:0] {
        MXR_IDLE,
        MXR_BYPASS,
        MXR_MX,
        MXR_DRAIN
    } mx_router_state_e;

    // Tag width: a single channel still needs a one-bit tag port.
    function automatic int unsigned mxr_chw(input int unsigned num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

    function automatic int unsigned mxr_cntw(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/redmule_mx_ch_fifo.sv
// Single-channel FIFO with synchronous clear; head word is read combinationally.
module redmule_mx_ch_fifo
    import redmule_pkg::*;
#(
    parameter int unsigned WIDTH = 576,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = mxr_cntw(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

    // No pass-through: a full FIFO refuses a push even while it is popped.
    assign push_ok = push_i && !full_o && !clear_i;
    assign pop_ok  = pop_i && !empty_o && !clear_i;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push_ok) wptr_d = wptr_q + PW'(1);
            if (pop_ok)  rptr_d = rptr_q + PW'(1);
            cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q] <= data_i;
    end

    // Storage is not reset, so an empty FIFO masks whatever stale word sits at the head.
    assign data_o = empty_o ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/redmule_mx_stream_router.sv
// Routes raw FP16 bypass beats or tagged MX-decoded beats into per-channel FIFOs,
// draining every channel before the source mode changes.
module redmule_mx_stream_router
    import redmule_pkg::*;
#(
    parameter int unsigned  NUM_CH       = 2,
    parameter int unsigned  DATAW_ALIGN  = 512,
    parameter int unsigned  BITW         = 16,
    parameter int unsigned  MX_NUM_LANES = 32,
    parameter int unsigned  FIFO_DEPTH   = 2,
    localparam int unsigned CHW          = mxr_chw(NUM_CH),
    localparam int unsigned STRBW        = DATAW_ALIGN / 8,
    localparam int unsigned DECW         = MX_NUM_LANES * BITW
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clear_i,
    input  logic                          mx_enable_i,
    input  logic [NUM_CH-1:0]             raw_valid_i,
    output logic [NUM_CH-1:0]             raw_ready_o,
    input  logic [NUM_CH*DATAW_ALIGN-1:0] raw_data_i,
    input  logic [NUM_CH*STRBW-1:0]       raw_strb_i,
    input  logic                          dec_valid_i,
    output logic                          dec_ready_o,
    input  logic [DECW-1:0]               dec_data_i,
    input  logic [CHW-1:0]                dec_ch_i,
    output logic [NUM_CH-1:0]             out_valid_o,
    input  logic [NUM_CH-1:0]             out_ready_i,
    output logic [NUM_CH*DATAW_ALIGN-1:0] out_data_o,
    output logic [NUM_CH*STRBW-1:0]       out_strb_o,
    output logic                          mode_o,
    output logic                          busy_o,
    output logic                          err_o
);

    localparam int unsigned FW   = DATAW_ALIGN + STRBW;
    localparam int unsigned CNTW = mxr_cntw(FIFO_DEPTH);

    mx_router_state_e state_q, state_d;
    logic             err_q, err_d;

    logic [NUM_CH-1:0] full, empty, nonempty, push, pop;
    logic [CNTW-1:0]   cnt      [NUM_CH];
    logic [FW-1:0]     fifo_in  [NUM_CH];
    logic [FW-1:0]     fifo_out [NUM_CH];

    logic                   tag_valid, tag_full;
    logic [DATAW_ALIGN-1:0] dec_ext;

    always_comb begin
        tag_valid = (32'(dec_ch_i) < NUM_CH);
        tag_full  = 1'b0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            if (dec_ch_i == CHW'(c)) tag_full = full[c];
        end
        dec_ext = '0;
        dec_ext[DECW-1:0] = dec_data_i;
    end

    // Readies depend only on state, full flags and the tag, never on out_ready_i.
    always_comb begin
        raw_ready_o = '0;
        dec_ready_o = 1'b0;
        if (state_q == MXR_BYPASS) raw_ready_o = ~full;
        if (state_q == MXR_MX)     dec_ready_o = tag_valid ? !tag_full : 1'b1;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MXR_IDLE:   state_d = mx_enable_i ? MXR_MX : MXR_BYPASS;
            MXR_BYPASS: if (mx_enable_i)  state_d = MXR_DRAIN;
            MXR_MX:     if (!mx_enable_i) state_d = MXR_DRAIN;
            MXR_DRAIN:  if (nonempty == '0) state_d = MXR_IDLE;
            default:    state_d = MXR_IDLE;
        endcase
        if (clear_i) state_d = MXR_IDLE;

        err_d = err_q;
        if (clear_i) begin
            err_d = 1'b0;
        end else if (state_q == MXR_MX && dec_valid_i && !tag_valid) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= MXR_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < int'(NUM_CH); gi++) begin : g_ch
            always_comb begin
                push[gi]    = 1'b0;
                fifo_in[gi] = {raw_strb_i[gi*STRBW +: STRBW], raw_data_i[gi*DATAW_ALIGN +: DATAW_ALIGN]};
                if (state_q == MXR_BYPASS) begin
                    push[gi] = raw_valid_i[gi] && raw_ready_o[gi];
                end else if (state_q == MXR_MX) begin
                    push[gi]    = dec_valid_i && dec_ready_o && tag_valid && (dec_ch_i == CHW'(gi));
                    fifo_in[gi] = {{STRBW{1'b1}}, dec_ext};
                end
            end

            assign pop[gi] = out_valid_o[gi] && out_ready_i[gi];

            redmule_mx_ch_fifo #(
                .WIDTH (FW),
                .DEPTH (FIFO_DEPTH)
            ) i_fifo (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .clear_i (clear_i),
                .push_i  (push[gi]),
                .data_i  (fifo_in[gi]),
                .pop_i   (pop[gi]),
                .data_o  (fifo_out[gi]),
                .full_o  (full[gi]),
                .empty_o (empty[gi]),
                .count_o (cnt[gi])
            );

            assign nonempty[gi]                                = (cnt[gi] != '0);
            assign out_valid_o[gi]                             = !empty[gi];
            assign out_data_o[gi*DATAW_ALIGN +: DATAW_ALIGN]   = fifo_out[gi][DATAW_ALIGN-1:0];
            assign out_strb_o[gi*STRBW +: STRBW]               = fifo_out[gi][DATAW_ALIGN +: STRBW];
        end
    endgenerate

    assign mode_o = (state_q == MXR_MX);
    assign busy_o = (nonempty != '0) || (state_q == MXR_DRAIN);
    assign err_o  = err_q;

endmodule

// File: doc/redmule_mx_stream_router.md
# redmule_mx_stream_router

Multi-channel successor to the two-stream MX input mux. It routes either raw FP16 bypass beats or tagged MX-decoded beats into per-channel output FIFOs feeding the RedMulE data FIFOs, with NUM_CH channels. A mode FSM drains all channels before switching between bypass and MX, so beats from the two sources are never interleaved. Decoded beats carry a channel tag; an out-of-range tag is dropped and recorded as a sticky error.

## Interface
- NUM_CH, 2: number of input/output channels (X, W, ...); ≥1.
- DATAW_ALIGN, 512: output and raw beat width in bits.
- BITW, 16: decoded element width.
- MX_NUM_LANES, 32: decoded elements per beat; MX_NUM_LANES*BITW ≤ DATAW_ALIGN.
- FIFO_DEPTH, 2: per-channel FIFO depth; power of two, ≥2.
- CHW, max(1,$clog2(NUM_CH)): derived tag width.
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- clear_i  in  1  synchronous clear: empties FIFOs and clears error; FSM→IDLE.
- mx_enable_i  in  1  requested mode (1 = MX decoded, 0 = FP16 bypass).
- raw_valid_i / raw_ready_o  in/out  NUM_CH  per-channel raw handshake.
- raw_data_i  in  NUM_CH×DATAW_ALIGN  raw beats.
- raw_strb_i  in  NUM_CH×DATAW_ALIGN/8  raw strobes.
- dec_valid_i / dec_ready_o  in/out  1  decoder handshake.
- dec_data_i  in  MX_NUM_LANES*BITW  decoded beat.
- dec_ch_i  in  CHW  destination channel of the decoded beat.
- out_valid_o / out_ready_i  out/in  NUM_CH  per-channel output handshake.
- out_data_o  out  NUM_CH×DATAW_ALIGN  output beats.
- out_strb_o  out  NUM_CH×DATAW_ALIGN/8  output strobes.
- mode_o  out  1  active mode (1 = MX); valid only in BYPASS/MX.
- busy_o  out  1  any FIFO non-empty, or FSM is in DRAIN.
- err_o  out  1  sticky: decoded beat with dec_ch_i ≥ NUM_CH was dropped.

## Operation
- FSM states: IDLE, BYPASS, MX, DRAIN.
  - IDLE → MX if mx_enable_i, else → BYPASS (one cycle in IDLE).
  - BYPASS/MX → DRAIN when mx_enable_i ≠ current mode.
  - DRAIN → IDLE when all FIFOs are empty, then re-evaluates as above.
  - In DRAIN no pushes are accepted; pops continue.
- BYPASS:
  - raw_ready_o[c] = !full[c]; dec_ready_o = 0.
  - Push stores raw_data_i/raw_strb_i unchanged.
- MX:
  - raw_ready_o = 0.
  - For a valid tag: dec_ready_o = !full[dec_ch_i].
  - For an invalid tag: dec_ready_o = 1; the beat is discarded and err_o is set.
  - Push stores dec_data_i zero-extended to DATAW_ALIGN (upper bits 0); strobe is all ones.
- Outputs:
  - out_valid_o[c] = !empty[c]; data/strb come from the FIFO head.
  - Pop on out_valid_o[c] && out_ready_i[c].
- Ready is derived from !full only. A full FIFO does not accept a push in the same cycle as a pop (no pass-through).
- Push and pop in the same cycle on a non-full, non-empty FIFO leave the count unchanged.
- Pointers wrap modulo FIFO_DEPTH; the count is $clog2(FIFO_DEPTH+1) bits.
- Each channel is independent: a full channel never stalls other channels in BYPASS. In MX, a full target channel stalls only the decoder.
- clear_i has priority over any push or pop in the same cycle.

## Timing
- Reset (rst_i high, async):
  - FSM = IDLE; all counts and pointers = 0; err_o = 0.
  - out_valid_o = 0; raw_ready_o = 0; dec_ready_o = 0; busy_o = 0; mode_o = 0.
  - out_data_o and out_strb_o read as 0.
- Latency: a beat accepted at edge N has out_valid_o high after edge N (one-cycle latency).
- All ready outputs are combinational from registered state plus dec_ch_i. There is no combinational path from out_ready_i to any ready output.
- Mode switch cost: drain time + 1 cycle DRAIN→IDLE + 1 cycle IDLE→new mode.
- A mx_enable_i toggle during DRAIN is re-evaluated only in IDLE. A toggle back to the original mode therefore still passes through IDLE.
- Reset asserted mid-transfer discards all buffered beats. No output valid is held across reset.

## Structure
- Shared package redmule_pkg holds:
  - typedef enum logic [1:0] {MXR_IDLE, MXR_BYPASS, MXR_MX, MXR_DRAIN} mx_router_state_e;
  - the derived-width functions.
- Sub-module redmule_mx_ch_fifo: a single-channel FIFO parameterised by width (DATAW_ALIGN + DATAW_ALIGN/8) and FIFO_DEPTH, with push/pop/clear, full/empty and count. It is instantiated NUM_CH times in a generate loop.
- The top level contains the FSM, the source muxing, zero-extension, tag decode and the error flag.

## Test plan
- Reset, mx_enable_i=0:
  - After 2 cycles, mode_o=0 and raw_ready_o all 1.
  - Push raw beat 0xA5…A5 with strb all ones on ch1 → out_valid_o[1] one cycle later with identical data; ch0 stays invalid.
- MX with FIFO_DEPTH=2:
  - Send 3 decoded beats tagged ch0 while out_ready_i=0 → dec_ready_o drops after 2 beats.
  - Raise out_ready_i → beats emerge in order, each with upper DATAW_ALIGN−512 bits zero and strb all ones.
- Mode switch: fill ch0 in BYPASS with 2 beats, then set mx_enable_i=1:
  - FSM enters DRAIN and raw_ready_o = 0; busy_o = 1.
  - After both pops, exactly 2 cycles pass before dec_ready_o can go high; mode_o then = 1.
- Invalid tag (NUM_CH=3, dec_ch_i=3):
  - dec_ready_o = 1, the beat is not stored, and err_o = 1 and stays set.
  - clear_i clears err_o.
- Simultaneous push/pop on ch0 with count=1 for 10 cycles → count stays 1, out_valid_o stays high, data sequence is preserved with no gaps.
- Assert rst_i with both FIFOs full → all out_valid_o = 0 immediately (asynchronous). After release, the first new beat appears with no stale data.
